mmio_timer: RTL

Memory-mapped timer peripheral answering the CPU data-memory bus (8-bit address, 16-bit data, single write-enable) alongside the data memory. Decodes a 4-word window, holds control/count/compare/status registers, counts prescaled clock ticks, and raises a sticky match flag plus an interrupt line. The top level uses `hit` to steer read data between this block and data memory.

---
 rtl/mmio_pkg.sv | 42 ++++
 rtl/mmio_timer_if.sv | 19 +
 rtl/mmio_prescaler.sv | 34 +++
 rtl/mmio_timer.sv | 108 ++++++++++
 4 files changed

// File: rtl/mmio_pkg.sv
// Shared definitions for the memory-mapped timer: register offsets, bit
// positions inside CTRL/STATUS, reset constants and the default window base.
package mmio_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 16;
    localparam int PSC_W  = 4;

    localparam logic [ADDR_W-1:0] BASE_ADDR_DEFAULT = 8'hF0;

    typedef enum logic [1:0] {
        OFF_CTRL    = 2'd0,
        OFF_COUNT   = 2'd1,
        OFF_COMPARE = 2'd2,
        OFF_STATUS  = 2'd3
    } reg_off_e;

    // CTRL bit positions
    localparam int EN      = 0;
    localparam int RELOAD  = 1;
    localparam int IE      = 2;
    localparam int PSC_LSB = 4;
    localparam int PSC_MSB = 7;

    // STATUS bit positions
    localparam int ST_MATCH = 0;
    localparam int ST_OVF   = 1;

    localparam logic [DATA_W-1:0] CTRL_WMASK   = 16'h00F7;
    localparam logic [DATA_W-1:0] STATUS_MASK  = 16'h0003;

    localparam logic [DATA_W-1:0] CTRL_RST     = 16'h0000;
    localparam logic [DATA_W-1:0] COUNT_RST    = 16'h0000;
    localparam logic [DATA_W-1:0] COMPARE_RST  = 16'hFFFF;
    localparam logic [DATA_W-1:0] STATUS_RST   = 16'h0000;

    // Masks a CTRL write so that bits 15:8 and 3 always read back as 0.
    function automatic logic [DATA_W-1:0] ctrl_wr_value(input logic [DATA_W-1:0] din);
        return din & CTRL_WMASK;
    endfunction

endpackage

// File: rtl/mmio_timer_if.sv
// CPU data-memory bus as seen by the timer: address/write data/strobe from the
// CPU, read data, window hit and interrupt back from the peripheral.
interface mmio_timer_if;
    import mmio_pkg::*;

    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] din;
    logic              we;
    logic [DATA_W-1:0] dout;
    logic              hit;
    logic              irq;

    modport master (output addr, output din, output we,
                    input  dout, input  hit, input  irq);

    modport slave  (input  addr, input  din, input  we,
                    output dout, output hit, output irq);

endinterface

// File: rtl/mmio_prescaler.sv
// 4-bit clock divider: tick fires when the phase counter reaches psc, then the
// phase restarts; disabled or restarted dividers sit at phase 0.
module mmio_prescaler
    import mmio_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [PSC_W-1:0] psc,
    input  logic             restart,
    output logic             tick
);

    logic [PSC_W-1:0] pc_q;
    logic [PSC_W-1:0] pc_d;

    assign tick = en && (pc_q == psc);

    always_comb begin
        pc_d = pc_q + 4'd1;
        if (restart || !en || tick) begin
            pc_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule

// File: rtl/mmio_timer.sv
// Timer peripheral in a 4-word window of the data-memory map: prescaled
// up-counter with compare match, overflow flag and level interrupt.
module mmio_timer
    import mmio_pkg::*;
#(
    parameter logic [ADDR_W-1:0] BASE_ADDR = BASE_ADDR_DEFAULT
)
(
    input  logic clk,
    input  logic reset,
    mmio_timer_if.slave bus
);

    logic [DATA_W-1:0] ctrl_q,    ctrl_d;
    logic [DATA_W-1:0] count_q,   count_d;
    logic [DATA_W-1:0] compare_q, compare_d;
    logic [DATA_W-1:0] status_q,  status_d;
    logic [DATA_W-1:0] rdata;
    logic [PSC_W-1:0]  psc;
    reg_off_e          off;
    logic              wr;
    logic              wr_ctrl, wr_count, wr_compare, wr_status;
    logic              tick, restart;
    logic              match_set, ovf_set;

    assign off        = reg_off_e'(bus.addr[1:0]);
    assign bus.hit    = (bus.addr[ADDR_W-1:2] == BASE_ADDR[ADDR_W-1:2]);
    assign wr         = bus.we && bus.hit;
    assign wr_ctrl    = wr && (off == OFF_CTRL);
    assign wr_count   = wr && (off == OFF_COUNT);
    assign wr_compare = wr && (off == OFF_COMPARE);
    assign wr_status  = wr && (off == OFF_STATUS);
    assign psc        = ctrl_q[PSC_MSB:PSC_LSB];

    // Re-phase the divider whenever its rate changes or it is being stopped.
    assign restart = wr_ctrl && ((bus.din[PSC_MSB:PSC_LSB] != psc) || !bus.din[EN]);

    mmio_prescaler u_prescaler (
        .clk     (clk),
        .reset   (reset),
        .en      (ctrl_q[EN]),
        .psc     (psc),
        .restart (restart),
        .tick    (tick)
    );

    always_comb begin
        ctrl_d    = ctrl_q;
        count_d   = count_q;
        compare_d = compare_q;
        status_d  = status_q;
        match_set = 1'b0;
        ovf_set   = 1'b0;

        // A CPU write to COUNT suppresses the tick entirely, flags included.
        if (wr_count) begin
            count_d = bus.din;
        end else if (tick) begin
            if (count_q == compare_q) begin
                match_set = 1'b1;
                count_d   = ctrl_q[RELOAD] ? '0 : count_q + 16'd1;
                ovf_set   = (count_q == 16'hFFFF) && !ctrl_q[RELOAD];
            end else begin
                count_d   = count_q + 16'd1;
                ovf_set   = (count_q == 16'hFFFF);
            end
        end

        if (wr_ctrl)    ctrl_d    = ctrl_wr_value(bus.din);
        if (wr_compare) compare_d = bus.din;
        if (wr_status)  status_d  = status_q & ~(bus.din & STATUS_MASK);

        // Hardware set events take priority over a same-cycle W1C.
        status_d[ST_MATCH] = status_d[ST_MATCH] | match_set;
        status_d[ST_OVF]   = status_d[ST_OVF]   | ovf_set;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q    <= CTRL_RST;
            count_q   <= COUNT_RST;
            compare_q <= COMPARE_RST;
            status_q  <= STATUS_RST;
        end else begin
            ctrl_q    <= ctrl_d;
            count_q   <= count_d;
            compare_q <= compare_d;
            status_q  <= status_d;
        end
    end

    always_comb begin
        rdata = '0;
        if (bus.hit) begin
            case (off)
                OFF_CTRL:    rdata = ctrl_q;
                OFF_COUNT:   rdata = count_q;
                OFF_COMPARE: rdata = compare_q;
                OFF_STATUS:  rdata = status_q;
                default:     rdata = '0;
            endcase
        end
    end

    assign bus.dout = rdata;
    assign bus.irq  = status_q[ST_MATCH] & ctrl_q[IE];

endmodule
